vga_sync_decoder: RTL and testbench
===================================

# vga_sync_decoder

Receive-side counterpart to the picture processing unit's VGA timing generator. The block samples the hsync/vsync pair the ppu drives toward the VGA DAC and recovers pixel coordinates and an active-video flag from the syncs alone. It checks every line and frame against the 1280x1024@60 (108 MHz) timing, declares lock after one clean frame, and flags timing faults. It is used as an on-chip timing monitor and as the coordinate source for a future frame-capture path.

## Interface
- H_TOTAL, 1688, clocks per line
- H_SYNC, 112, hsync width in clocks
- H_BACK, 248, clocks from hsync trailing edge to first active pixel
- H_ACTIVE, 1280, active pixels per line
- V_TOTAL, 1066, lines per frame
- V_SYNC, 3, vsync width in lines
- V_BACK, 38, lines from vsync trailing edge to first active line
- V_ACTIVE, 1024, active lines per frame
- SYNC_POL, 0, active level of both syncs (0 = active-low)

Ports (name, direction, width, meaning):
- clock  in  1  pixel clock, 108 MHz, the only clock
- reset  in  1  asynchronous, active-low; all state cleared while low
- hsync  in  1  horizontal sync from ppu, synchronous to clock
- vsync  in  1  vertical sync from ppu, synchronous to clock
- locked  out  1  timing verified, coordinates valid
- active_video  out  1  current sample is an active pixel (only while locked)
- pixel_x  out  11  column 0..1279 when active_video, else 0
- pixel_y  out  11  row 0..1023 when active_video, else 0
- frame_start  out  1  one-cycle pulse at each recovered frame start
- timing_err  out  1  one-cycle pulse on any check failure while LOCKED
- err_flags  out  4  sticky: [0] line period, [1] hsync width, [2] frame length, [3] vsync width or hsync timeout

## Operation
- Input stage: hsync/vsync registered twice (s1, s2), normalised by SYNC_POL to active-high. A leading edge is s1 active with s2 inactive; a trailing edge is the reverse.
- hcnt (12 bit): set to 0 on the cycle an hsync leading edge is detected, otherwise increments, saturating at 4095.
- hwidth: counts clocks with s1 active. On the trailing edge, if the value differs from H_SYNC, set err_flags[1].
- On an hsync leading edge, if hcnt+1 != H_TOTAL, set err_flags[0]. This check is skipped on the first edge after reset or after a timeout.
- vsync leading edge sets vpend. The next hsync leading edge, or the same cycle if coincident, is the frame start: vcnt <= 0, vpend cleared, frame_start pulses. On other hsync edges vcnt increments, saturating at 2047.
- At frame start, if vcnt+1 != V_TOTAL, set err_flags[2]. This check is skipped at the first frame start seen from SEARCH.
- vwidth counts hsync leading edges while vsync is active. On the vsync trailing edge, if the count differs from V_SYNC, set err_flags[3].
- Timeout: if hcnt reaches 2*H_TOTAL, set err_flags[3] and return to SEARCH.
- err_flags bits set only in ACQUIRE or LOCKED. Bits persist until reset.
- State machine:
  - SEARCH: go to ACQUIRE at the first frame start.
  - ACQUIRE: a per-frame error latch clears at each frame start. At a frame start with no error in the ending frame and a correct frame length, go to LOCKED; otherwise stay in ACQUIRE.
  - LOCKED: any check failure pulses timing_err and goes to ACQUIRE in the same cycle. A timeout goes to SEARCH.
- active_video = locked AND (H_SYNC+H_BACK <= hcnt < H_SYNC+H_BACK+H_ACTIVE) AND (V_SYNC+V_BACK <= vcnt < V_SYNC+V_BACK+V_ACTIVE).
- pixel_x = hcnt − (H_SYNC+H_BACK) and pixel_y = vcnt − (V_SYNC+V_BACK), truncated to 11 bits.

## Timing
- Reset values:
  - locked, active_video, frame_start, timing_err = 0
  - pixel_x, pixel_y = 0
  - err_flags = 0
  - state = SEARCH
  - hcnt, vcnt = 0
- Latency: an hsync edge at the pins is detected 2 clocks later. pixel_x/pixel_y/active_video are registered outputs, 3 clocks behind the ppu pixel they describe.
- locked rises in the cycle after the second frame start following reset, i.e. one full frame after SEARCH exits, with nominal input.
- Error detection and the timing_err pulse occur in the same cycle as the triggering edge. locked falls in the next cycle.
- Reset asserted mid-frame clears everything immediately. After reset release, lock needs two frame starts again.

## Test plan
- Nominal timing: a bus-functional ppu model drives 3 frames → locked=1 after the 2nd frame start. The first active pixel shows pixel_x=0, pixel_y=0; the last shows 1279, 1023. err_flags=0 and frame_start pulses once per 1688*1066 clocks.
- Line period fault: one line is 1689 clocks while locked → timing_err pulses once, err_flags[0]=1, locked drops, and relocks one clean frame later.
- hsync width fault: one pulse 111 clocks wide → err_flags[1]=1 and timing_err pulses at the trailing edge.
- Sync loss: hold hsync inactive for 3376+ clocks → err_flags[3]=1, locked=0, state SEARCH. After resuming, lock returns after two frame starts.
- Frame length fault: a 1065-line frame → err_flags[2] is set at that frame start and locked=0.
- Async reset mid-line while locked → all outputs 0 immediately; pixel coordinates stay 0 until relock.

Source files
------------

// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: recovers pixel coordinates, active video and lock status from an hsync/vsync pair
// Ports:
//   clock         pixel clock, the only clock
//   reset         asynchronous active-low reset
//   hsync, vsync  sync inputs from the ppu, active level given by SYNC_POL
//   locked        timing verified over a full clean frame, coordinates valid
//   active_video  current sample is an active pixel (only while locked)
//   pixel_x/y     column/row of the active pixel, 0 otherwise
//   frame_start   one-cycle pulse at each recovered frame start
//   timing_err    one-cycle pulse on any check failure while locked
//   err_flags     sticky: [0] line period, [1] hsync width, [2] frame length, [3] vsync width or hsync timeout
module vga_sync_decoder #(
    parameter int H_TOTAL  = 1688,
    parameter int H_SYNC   = 112,
    parameter int H_BACK   = 248,
    parameter int H_ACTIVE = 1280,
    parameter int V_TOTAL  = 1066,
    parameter int V_SYNC   = 3,
    parameter int V_BACK   = 38,
    parameter int V_ACTIVE = 1024,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        hsync,
    input  logic        vsync,
    output logic        locked,
    output logic        active_video,
    output logic [10:0] pixel_x,
    output logic [10:0] pixel_y,
    output logic        frame_start,
    output logic        timing_err,
    output logic [3:0]  err_flags
);
    localparam logic [1:0] SEARCH  = 2'd0;
    localparam logic [1:0] ACQUIRE = 2'd1;
    localparam logic [1:0] LOCKED  = 2'd2;
    localparam int HOFF = H_SYNC + H_BACK;
    localparam int VOFF = V_SYNC + V_BACK;

    logic        hs1, hs2, vs1, vs2, h_seen, vpend, ferr;
    logic [11:0] hcnt, hwidth;
    logic [10:0] vcnt, vwidth;
    logic [1:0]  state, state_n;
    logic        h_lead, h_trail, v_lead, v_trail, fs, timeout, av_n;
    logic [3:0]  err;

    always_comb begin
        h_lead  = hs1 & ~hs2;
        h_trail = ~hs1 & hs2;
        v_lead  = vs1 & ~vs2;
        v_trail = ~vs1 & vs2;
        // a pending or coincident vsync edge turns the next hsync edge into the frame start
        fs      = h_lead & (vpend | v_lead);
        timeout = hcnt == 12'(2 * H_TOTAL);
        // the first line edge after reset or timeout has no previous edge to measure against
        err[0]  = h_lead & h_seen & (hcnt + 12'd1 != 12'(H_TOTAL));
        err[1]  = h_trail & (hwidth != 12'(H_SYNC));
        err[2]  = fs & (state != SEARCH) & (vcnt + 11'd1 != 11'(V_TOTAL));
        err[3]  = (v_trail & (vwidth != 11'(V_SYNC))) | timeout;
        state_n = (timeout || state > LOCKED) ? SEARCH :
                  (state == SEARCH && fs) ? ACQUIRE :
                  (state == ACQUIRE && fs && !ferr && err == 4'd0) ? LOCKED :
                  (state == LOCKED && err != 4'd0) ? ACQUIRE : state;
        // gate with the next state so active_video never outlives locked
        av_n    = (state_n == LOCKED) &&
                  hcnt >= 12'(HOFF) && hcnt < 12'(HOFF + H_ACTIVE) &&
                  vcnt >= 11'(VOFF) && vcnt < 11'(VOFF + V_ACTIVE);
        locked      = state == LOCKED;
        frame_start = fs;
        timing_err  = (state == LOCKED) && err != 4'd0;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hs1          <= 1'b0;
            hs2          <= 1'b0;
            vs1          <= 1'b0;
            vs2          <= 1'b0;
            hcnt         <= '0;
            hwidth       <= '0;
            h_seen       <= 1'b0;
            vcnt         <= '0;
            vwidth       <= '0;
            vpend        <= 1'b0;
            ferr         <= 1'b0;
            err_flags    <= '0;
            state        <= SEARCH;
            active_video <= 1'b0;
            pixel_x      <= '0;
            pixel_y      <= '0;
        end else begin
            hs1          <= hsync == SYNC_POL;
            hs2          <= hs1;
            vs1          <= vsync == SYNC_POL;
            vs2          <= vs1;
            hcnt         <= h_lead ? '0 : hcnt + {11'd0, hcnt != '1};
            hwidth       <= hs1 ? hwidth + {11'd0, hwidth != '1} : '0;
            h_seen       <= ~timeout & (h_seen | h_lead);
            vcnt         <= fs ? '0 : vcnt + {10'd0, h_lead & (vcnt != '1)};
            vwidth       <= vs1 ? vwidth + {10'd0, h_lead & (vwidth != '1)} : '0;
            vpend        <= ~fs & (vpend | v_lead);
            ferr         <= ~fs & (ferr | (err != 4'd0));
            err_flags    <= err_flags | ((state != SEARCH) ? err : 4'd0);
            state        <= state_n;
            active_video <= av_n;
            pixel_x      <= av_n ? 11'(hcnt - 12'(HOFF)) : '0;
            pixel_y      <= av_n ? vcnt - 11'(VOFF) : '0;
        end
    end
endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb_vga_sync_decoder: directed checks of sync recovery, lock and fault detection on a reduced raster
module tb_vga_sync_decoder;
    localparam int HT = 40, HS = 4, HB = 6, HA = 24;
    localparam int VT = 12, VS = 2, VB = 3, VA = 5;

    logic        clock = 1'b0, reset = 1'b0, hsync = 1'b1, vsync = 1'b1;
    logic        locked, active_video, frame_start, timing_err;
    logic [10:0] pixel_x, pixel_y;
    logic [3:0]  err_flags;

    int n_vec = 0, n_bad = 0;
    int tick_no = 0, fs_mark = 0, lead_mark = 0, trail_mark = 0;
    int fs_cnt = 0, fs_gap = 0, fs_tick = 0, te_cnt = 0, te_tick = 0, lk_gap = 0, fall_cnt = 0;
    int av_cnt = 0, fx = -1, fy = -1, lx = -1, ly = -1, zc_bad = 0;
    bit lk_q = 1'b0, newf = 1'b0;

    vga_sync_decoder #(
        .H_TOTAL(HT), .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA),
        .V_TOTAL(VT), .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .SYNC_POL(1'b0)
    ) dut (
        .clock(clock), .reset(reset), .hsync(hsync), .vsync(vsync),
        .locked(locked), .active_video(active_video), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .frame_start(frame_start), .timing_err(timing_err), .err_flags(err_flags)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (frame_start) begin
            fs_cnt++;
            fs_gap = tick_no - fs_tick;
            fs_tick = tick_no;
            newf = 1'b1;
        end
        if (timing_err) begin
            te_cnt++;
            te_tick = tick_no;
        end
        if (locked && !lk_q) lk_gap = tick_no - fs_tick;
        if (!locked && lk_q) fall_cnt++;
        lk_q = locked;
        if (active_video) begin
            av_cnt++;
            if (newf) begin
                fx = int'(pixel_x);
                fy = int'(pixel_y);
                newf = 1'b0;
            end
            lx = int'(pixel_x);
            ly = int'(pixel_y);
        end
        if ((!active_video && (pixel_x != 11'd0 || pixel_y != 11'd0)) || (active_video && !locked)) zc_bad++;
    end

    task automatic tick(input bit h, input bit v);
        @(posedge clock);
        #1;
        tick_no++;
        hsync = ~h;
        vsync = ~v;
    endtask

    task automatic frame(input int nl, input int bl, input int blen, input int bhw, input int stop);
        int n;
        n = 0;
        for (int l = 0; l < nl; l++) begin
            int len, hw;
            len = (l == bl) ? blen : HT;
            hw = (l == bl) ? bhw : HS;
            for (int c = 0; c < len; c++) begin
                if (stop >= 0 && n == stop) return;
                tick(c < hw, l < VS);
                if (l == 0 && c == 0) fs_mark = tick_no;
                if (l == bl + 1 && c == 0) lead_mark = tick_no;
                if (l == bl && c == hw) trail_mark = tick_no;
                n++;
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        reset = 1'b1;
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);
        n_vec++; if (locked !== 1'b0) begin n_bad++; $display("FAIL rst_locked got=%0d exp=0", locked); end
        n_vec++; if (active_video !== 1'b0) begin n_bad++; $display("FAIL rst_av got=%0d exp=0", active_video); end
        n_vec++; if (pixel_x !== 11'd0) begin n_bad++; $display("FAIL rst_px got=%0d exp=0", pixel_x); end
        n_vec++; if (pixel_y !== 11'd0) begin n_bad++; $display("FAIL rst_py got=%0d exp=0", pixel_y); end
        n_vec++; if (frame_start !== 1'b0) begin n_bad++; $display("FAIL rst_fs got=%0d exp=0", frame_start); end
        n_vec++; if (timing_err !== 1'b0) begin n_bad++; $display("FAIL rst_te got=%0d exp=0", timing_err); end
        n_vec++; if (err_flags !== 4'd0) begin n_bad++; $display("FAIL rst_flags got=%b exp=0000", err_flags); end
        reset = 1'b1;
    endtask

    task automatic test_nominal();
        int f0, t0, a0;
        do_reset();
        f0 = fs_cnt; t0 = te_cnt; a0 = av_cnt;
        for (int i = 0; i < 3; i++) frame(VT, -1, 0, 0, -1);
        n_vec++; if (locked !== 1'b1) begin n_bad++; $display("FAIL nom_locked got=%0d exp=1", locked); end
        n_vec++; if (fs_cnt - f0 != 3) begin n_bad++; $display("FAIL nom_fs_count got=%0d exp=3", fs_cnt - f0); end
        n_vec++; if (fs_gap != HT * VT) begin n_bad++; $display("FAIL nom_fs_gap got=%0d exp=%0d", fs_gap, HT * VT); end
        n_vec++; if (lk_gap != 1) begin n_bad++; $display("FAIL nom_lock_delay got=%0d exp=1", lk_gap); end
        n_vec++; if (fx != 0 || fy != 0) begin n_bad++; $display("FAIL nom_first_px got=%0d,%0d exp=0,0", fx, fy); end
        n_vec++; if (lx != HA - 1 || ly != VA - 1) begin n_bad++; $display("FAIL nom_last_px got=%0d,%0d exp=%0d,%0d", lx, ly, HA - 1, VA - 1); end
        n_vec++; if (av_cnt - a0 != 2 * HA * VA) begin n_bad++; $display("FAIL nom_av_count got=%0d exp=%0d", av_cnt - a0, 2 * HA * VA); end
        n_vec++; if (err_flags !== 4'd0) begin n_bad++; $display("FAIL nom_flags got=%b exp=0000", err_flags); end
        n_vec++; if (te_cnt - t0 != 0) begin n_bad++; $display("FAIL nom_te got=%0d exp=0", te_cnt - t0); end
    endtask

    task automatic test_line_period();
        int t0, l0;
        do_reset();
        t0 = te_cnt; l0 = fall_cnt;
        frame(VT, -1, 0, 0, -1);
        frame(VT, -1, 0, 0, -1);
        frame(VT, 6, HT + 1, HS, -1);
        n_vec++; if (te_cnt - t0 != 1) begin n_bad++; $display("FAIL lp_te_count got=%0d exp=1", te_cnt - t0); end
        n_vec++; if (te_tick != lead_mark + 1) begin n_bad++; $display("FAIL lp_te_time got=%0d exp=%0d", te_tick, lead_mark + 1); end
        n_vec++; if (err_flags !== 4'b0001) begin n_bad++; $display("FAIL lp_flags got=%b exp=0001", err_flags); end
        n_vec++; if (fall_cnt - l0 != 1) begin n_bad++; $display("FAIL lp_lock_drop got=%0d exp=1", fall_cnt - l0); end
        frame(VT, -1, 0, 0, -1);
        n_vec++; if (locked !== 1'b0) begin n_bad++; $display("FAIL lp_still_unlocked got=%0d exp=0", locked); end
        frame(VT, -1, 0, 0, -1);
        n_vec++; if (locked !== 1'b1) begin n_bad++; $display("FAIL lp_relock got=%0d exp=1", locked); end
        n_vec++; if (lk_gap != 1) begin n_bad++; $display("FAIL lp_relock_delay got=%0d exp=1", lk_gap); end
    endtask

    task automatic test_hsync_width();
        int t0;
        do_reset();
        t0 = te_cnt;
        frame(VT, -1, 0, 0, -1);
        frame(VT, -1, 0, 0, -1);
        frame(VT, 4, HT, HS - 1, -1);
        n_vec++; if (te_cnt - t0 != 1) begin n_bad++; $display("FAIL hw_te_count got=%0d exp=1", te_cnt - t0); end
        n_vec++; if (te_tick != trail_mark + 1) begin n_bad++; $display("FAIL hw_te_time got=%0d exp=%0d", te_tick, trail_mark + 1); end
        n_vec++; if (err_flags !== 4'b0010) begin n_bad++; $display("FAIL hw_flags got=%b exp=0010", err_flags); end
        n_vec++; if (locked !== 1'b0) begin n_bad++; $display("FAIL hw_locked got=%0d exp=0", locked); end
    endtask

    task automatic test_sync_loss();
        int t0, f0;
        do_reset();
        frame(VT, -1, 0, 0, -1);
        frame(VT, -1, 0, 0, -1);
        t0 = te_cnt;
        for (int i = 0; i < 2 * HT + 20; i++) tick(1'b0, 1'b0);
        n_vec++; if (err_flags !== 4'b1000) begin n_bad++; $display("FAIL sl_flags got=%b exp=1000", err_flags); end
        n_vec++; if (locked !== 1'b0) begin n_bad++; $display("FAIL sl_locked got=%0d exp=0", locked); end
        n_vec++; if (te_cnt - t0 != 1) begin n_bad++; $display("FAIL sl_te_count got=%0d exp=1", te_cnt - t0); end
        f0 = fs_cnt;
        frame(VT, -1, 0, 0, -1);
        n_vec++; if (locked !== 1'b0) begin n_bad++; $display("FAIL sl_one_frame got=%0d exp=0", locked); end
        frame(VT, -1, 0, 0, -1);
        n_vec++; if (locked !== 1'b1) begin n_bad++; $display("FAIL sl_relock got=%0d exp=1", locked); end
        n_vec++; if (fs_cnt - f0 != 2) begin n_bad++; $display("FAIL sl_fs_count got=%0d exp=2", fs_cnt - f0); end
        n_vec++; if (err_flags !== 4'b1000) begin n_bad++; $display("FAIL sl_flags_after got=%b exp=1000", err_flags); end
    endtask

    task automatic test_frame_length();
        int t0;
        do_reset();
        frame(VT, -1, 0, 0, -1);
        frame(VT, -1, 0, 0, -1);
        t0 = te_cnt;
        frame(VT - 1, -1, 0, 0, -1);
        frame(VT, -1, 0, 0, -1);
        n_vec++; if (te_cnt - t0 != 1) begin n_bad++; $display("FAIL fl_te_count got=%0d exp=1", te_cnt - t0); end
        n_vec++; if (te_tick != fs_mark + 1) begin n_bad++; $display("FAIL fl_te_time got=%0d exp=%0d", te_tick, fs_mark + 1); end
        n_vec++; if (err_flags !== 4'b0100) begin n_bad++; $display("FAIL fl_flags got=%b exp=0100", err_flags); end
        n_vec++; if (locked !== 1'b0) begin n_bad++; $display("FAIL fl_locked got=%0d exp=0", locked); end
    endtask

    task automatic test_async_reset();
        int a0;
        do_reset();
        frame(VT, -1, 0, 0, -1);
        frame(VT, -1, 0, 0, -1);
        frame(VT, -1, 0, 0, 6 * HT + 21);
        n_vec++; if (active_video !== 1'b1) begin n_bad++; $display("FAIL ar_av_before got=%0d exp=1", active_video); end
        n_vec++; if (pixel_x !== 11'd7) begin n_bad++; $display("FAIL ar_px_before got=%0d exp=7", pixel_x); end
        n_vec++; if (pixel_y !== 11'd1) begin n_bad++; $display("FAIL ar_py_before got=%0d exp=1", pixel_y); end
        #1 reset = 1'b0;
        #1;
        n_vec++; if (locked !== 1'b0) begin n_bad++; $display("FAIL ar_locked got=%0d exp=0", locked); end
        n_vec++; if (active_video !== 1'b0) begin n_bad++; $display("FAIL ar_av got=%0d exp=0", active_video); end
        n_vec++; if (pixel_x !== 11'd0 || pixel_y !== 11'd0) begin n_bad++; $display("FAIL ar_pxy got=%0d,%0d exp=0,0", pixel_x, pixel_y); end
        n_vec++; if (err_flags !== 4'd0) begin n_bad++; $display("FAIL ar_flags got=%b exp=0000", err_flags); end
        tick(1'b0, 1'b0);
        reset = 1'b1;
        tick(1'b0, 1'b0);
        a0 = av_cnt;
        frame(VT, -1, 0, 0, -1);
        n_vec++; if (locked !== 1'b0) begin n_bad++; $display("FAIL ar_one_frame got=%0d exp=0", locked); end
        n_vec++; if (av_cnt - a0 != 0) begin n_bad++; $display("FAIL ar_av_unlocked got=%0d exp=0", av_cnt - a0); end
        frame(VT, -1, 0, 0, -1);
        n_vec++; if (locked !== 1'b1) begin n_bad++; $display("FAIL ar_relock got=%0d exp=1", locked); end
        n_vec++; if (zc_bad != 0) begin n_bad++; $display("FAIL coord_zero_when_idle got=%0d exp=0", zc_bad); end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_line_period();
        test_hsync_width();
        test_sync_loss();
        test_frame_length();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
